// File: rtl/counter_pkg.sv
// Shared types and sizing helpers for the up/down modulus counter family.
// Saturating variants are built with UPDOWN_COUNTER_SATURATE_EN defined.
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } count_dir_e;

   localparam int DEFAULT_WIDTH = 3;

   // Smallest counter width able to hold every value 0..modulus-1.
   function automatic int count_width(input int modulus);
      return (modulus <= 2) ? 1 : $clog2(modulus);
   endfunction

   // Full binary range of a counter of the given width.
   function automatic int default_modulus(input int width);
      return 1 << width;
   endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Next-state arithmetic for updown_counter_mod: next count, wrap pulse and overflow set.
// Wrap-around by default; saturates at the limits when UPDOWN_COUNTER_SATURATE_EN is defined.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = default_modulus(WIDTH)
)(
   input  logic [WIDTH-1:0] q,
   input  logic             up_dn,
   input  logic             en,
   output logic [WIDTH-1:0] q_next,
   output logic             tc_next,
   output logic             ovf_set
);

   localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
`ifdef UPDOWN_COUNTER_SATURATE_EN
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);
`else
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
`endif

   logic [WIDTH:0] inc;
   logic [WIDTH:0] dec;
   count_dir_e     dir;

   // The extra bit keeps the carry when MODULUS = 2**WIDTH and flags borrow out of zero.
   assign inc = {1'b0, q} + (WIDTH+1)'(1);
   assign dec = {1'b0, q} - (WIDTH+1)'(1);
   assign dir = count_dir_e'(up_dn);

   always_comb begin
      q_next  = q;
      tc_next = 1'b0;
      ovf_set = 1'b0;
      if (en) begin
         if (dir == DIR_UP) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
            if (inc >= MOD_EXT) begin
               ovf_set = 1'b1;
            end else begin
               q_next  = inc[WIDTH-1:0];
               tc_next = (inc == MAX_EXT);
            end
`else
            if (inc >= MOD_EXT) begin
               q_next  = '0;
               tc_next = 1'b1;
               ovf_set = 1'b1;
            end else begin
               q_next = inc[WIDTH-1:0];
            end
`endif
         end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
            if (dec[WIDTH]) begin
               ovf_set = 1'b1;
            end else begin
               q_next  = dec[WIDTH-1:0];
               tc_next = (dec == '0);
            end
`else
            if (dec[WIDTH]) begin
               q_next  = MAX_Q;
               tc_next = 1'b1;
               ovf_set = 1'b1;
            end else begin
               q_next = dec[WIDTH-1:0];
            end
`endif
         end
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Loadable up/down modulus counter with registered terminal-count pulse and sticky overflow.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = default_modulus(WIDTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load_en,
   input  logic [WIDTH-1:0] d,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_reg;
   logic             tc_reg;
   logic             ovf_reg;
   logic [WIDTH-1:0] q_next;
   logic             tc_next;
   logic             ovf_set;
   logic [WIDTH-1:0] load_val;

   counter_next_calc #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next_calc (
      .q       (q_reg),
      .up_dn   (up_dn),
      .en      (en),
      .q_next  (q_next),
      .tc_next (tc_next),
      .ovf_set (ovf_set)
   );

   // Out-of-range load values are clamped so q never leaves 0..MODULUS-1.
   assign load_val = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg   <= '0;
         tc_reg  <= 1'b0;
         ovf_reg <= 1'b0;
      end else begin
         if (load_en) begin
            q_reg  <= load_val;
            tc_reg <= 1'b0;
         end else begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
         end
         // A wrap in the same cycle as a clear keeps the flag set.
         if (!load_en && ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign q   = q_reg;
   assign tc  = tc_reg;
   assign ovf = ovf_reg;

endmodule
